aq_mmu_sysmap_ctrl: RTL and testbench

- Owns the sysmap region registers: REGION_NUM upper-boundary addresses plus attribute flags.
- Arbitrates physical-address attribute lookups from IFU and LSU and sequences one lookup at a time through the per-region compare cells.
- Applies CP0 configuration writes without disturbing an in-flight lookup.
- Sits in the MMU between the PA generation path and the cache/bus attribute consumers.

---
 rtl/aq_mmu_sysmap_pkg.sv | 27 ++
 rtl/aq_mmu_sysmap_hit.sv | 19 +
 rtl/aq_mmu_sysmap_rr_arb.sv | 34 +++
 rtl/aq_mmu_sysmap_ctrl.sv | 163 ++++++++++++++++
 tb/tb_aq_mmu_sysmap_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aq_mmu_sysmap_pkg.sv
// Shared definitions for the sysmap attribute block.
//   REGION_NUM / ADDR_WIDTH / FLG_WIDTH / DFLT_FLG : geometry and no-hit attributes
//   sysmap_state_e                                 : lookup sequencer state encoding
//   FLG_*                                          : bit positions inside a flag word
package aq_mmu_sysmap_pkg;

  localparam int REGION_NUM = 8;
  localparam int ADDR_WIDTH = 28;   // PA[39:12]
  localparam int FLG_WIDTH  = 5;
  localparam int IDX_WIDTH  = $clog2(REGION_NUM);

  localparam logic [FLG_WIDTH-1:0] DFLT_FLG = 5'b10000;

  // Flag word layout {SO, C, B, SH, SEC}
  localparam int FLG_SO  = 4;
  localparam int FLG_C   = 3;
  localparam int FLG_B   = 2;
  localparam int FLG_SH  = 1;
  localparam int FLG_SEC = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LKUP = 2'b01,
    ST_RESP = 2'b10
  } sysmap_state_e;

endpackage

// File: rtl/aq_mmu_sysmap_hit.sv
// Single-region compare cell: reports whether addr lies in [bottom, top).
//   is_first : region 0 has no lower bound
//   addr     : physical address under lookup
//   bottom   : upper boundary of the previous region
//   top      : upper boundary of this region (0 = empty region)
//   hit      : addr falls inside this region
module aq_mmu_sysmap_hit
  import aq_mmu_sysmap_pkg::*;
(
  input  logic                  is_first,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] bottom,
  input  logic [ADDR_WIDTH-1:0] top,
  output logic                  hit
);

  assign hit = (is_first | (addr >= bottom)) & (addr < top);

endmodule

// File: rtl/aq_mmu_sysmap_rr_arb.sv
// Two-way round-robin arbiter between IFU and LSU lookup requests.
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : grants are allowed this cycle
//   req_ifu, req_lsu  : request lines
//   gnt_ifu, gnt_lsu  : one-hot (or zero) grant, combinational
module aq_mmu_sysmap_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_ifu,
  input  logic req_lsu,
  output logic gnt_ifu,
  output logic gnt_lsu
);

  // ptr_lsu = 1 means LSU wins a tie. Out of reset LSU is favoured.
  logic ptr_lsu;

  assign gnt_lsu = en & req_lsu & (~req_ifu | ptr_lsu);
  assign gnt_ifu = en & req_ifu & (~req_lsu | ~ptr_lsu);

  // The pointer always moves to the side that did not win, even when the
  // winner was the only requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_lsu <= 1'b1;
    end else if (gnt_lsu) begin
      ptr_lsu <= 1'b0;
    end else if (gnt_ifu) begin
      ptr_lsu <= 1'b1;
    end
  end

endmodule

// File: rtl/aq_mmu_sysmap_ctrl.sv
// Sysmap region registers plus a lookup sequencer shared by IFU and LSU.
//   cpuclk, cpurst_b        : clock, asynchronous active-low reset
//   ifu_sysmap_req_*        : IFU lookup request / address, sysmap_ifu_req_rdy grant
//   lsu_sysmap_req_*        : LSU lookup request / address, sysmap_lsu_req_rdy grant
//   sysmap_rsp_*            : one-cycle result pulse with requester id, hit, index, flags
//   cp0_sysmap_*            : configuration write (sel 0 = top address, 1 = flags)
//   sysmap_cp0_busy         : configuration write pending
//   sysmap_dbg_state        : current sequencer state
//
// Handshake: a requester raises vld with a stable addr and holds both until it
// sees its rdy high; the request is taken at the clock edge ending that cycle.
// rdy never depends on anything but vld, the sequencer state and cp0 activity.
module aq_mmu_sysmap_ctrl
  import aq_mmu_sysmap_pkg::*;
(
  input  logic                  cpuclk,
  input  logic                  cpurst_b,
  input  logic                  ifu_sysmap_req_vld,
  input  logic [ADDR_WIDTH-1:0] ifu_sysmap_req_addr,
  output logic                  sysmap_ifu_req_rdy,
  input  logic                  lsu_sysmap_req_vld,
  input  logic [ADDR_WIDTH-1:0] lsu_sysmap_req_addr,
  output logic                  sysmap_lsu_req_rdy,
  output logic                  sysmap_rsp_vld,
  output logic                  sysmap_rsp_id,
  output logic                  sysmap_rsp_hit,
  output logic [IDX_WIDTH-1:0]  sysmap_rsp_idx,
  output logic [FLG_WIDTH-1:0]  sysmap_rsp_flg,
  input  logic                  cp0_sysmap_wen,
  input  logic                  cp0_sysmap_sel,
  input  logic [IDX_WIDTH-1:0]  cp0_sysmap_idx,
  input  logic [ADDR_WIDTH-1:0] cp0_sysmap_wdata,
  output logic                  sysmap_cp0_busy,
  output logic [1:0]            sysmap_dbg_state
);

  sysmap_state_e         state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  id_q;

  logic [ADDR_WIDTH-1:0] top_q [REGION_NUM];
  logic [FLG_WIDTH-1:0]  flg_q [REGION_NUM];

  logic                  grant_en;
  logic                  gnt_ifu;
  logic                  gnt_lsu;
  logic                  idx_ok;

  logic [REGION_NUM-1:0] hit_vec;
  logic [ADDR_WIDTH-1:0] bottom_v [REGION_NUM];
  logic                  lk_hit;
  logic [IDX_WIDTH-1:0]  lk_idx;
  logic [FLG_WIDTH-1:0]  lk_flg;

  assign sysmap_dbg_state = state_q;

  // A write always lands on the edge right after wen: in IDLE/RESP nothing
  // reads the registers at that edge, and in LKUP the result is captured on
  // that same edge from the pre-write values. The write slot therefore never
  // has to hold an entry across a cycle and busy stays low.
  assign sysmap_cp0_busy = 1'b0;

  // A cp0 write takes the cycle; no lookup is granted alongside it.
  assign grant_en = ((state_q == ST_IDLE) | (state_q == ST_RESP)) & ~cp0_sysmap_wen;

  aq_mmu_sysmap_rr_arb u_arb (
    .clk     (cpuclk),
    .rst_n   (cpurst_b),
    .en      (grant_en),
    .req_ifu (ifu_sysmap_req_vld),
    .req_lsu (lsu_sysmap_req_vld),
    .gnt_ifu (gnt_ifu),
    .gnt_lsu (gnt_lsu)
  );

  assign sysmap_ifu_req_rdy = gnt_ifu;
  assign sysmap_lsu_req_rdy = gnt_lsu;

  // Region compare cells; region i starts where region i-1 ends.
  for (genvar i = 0; i < REGION_NUM; i++) begin : g_region
    if (i == 0) begin : g_first
      assign bottom_v[i] = '0;
    end else begin : g_rest
      assign bottom_v[i] = top_q[i-1];
    end

    aq_mmu_sysmap_hit u_hit (
      .is_first (i == 0),
      .addr     (addr_q),
      .bottom   (bottom_v[i]),
      .top      (top_q[i]),
      .hit      (hit_vec[i])
    );
  end

  // Lowest-index hit wins: scan downward so the last assignment is the lowest.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    lk_flg = DFLT_FLG;
    for (int i = REGION_NUM - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        lk_hit = 1'b1;
        lk_idx = i[IDX_WIDTH-1:0];
        lk_flg = flg_q[i];
      end
    end
  end

  assign idx_ok = (int'(cp0_sysmap_idx) < REGION_NUM);

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < REGION_NUM; i++) begin
        top_q[i] <= '0;
        flg_q[i] <= DFLT_FLG;
      end
    end else if (cp0_sysmap_wen && idx_ok) begin
      if (cp0_sysmap_sel) begin
        flg_q[cp0_sysmap_idx] <= cp0_sysmap_wdata[FLG_WIDTH-1:0];
      end else begin
        top_q[cp0_sysmap_idx] <= cp0_sysmap_wdata;
      end
    end
  end

  // Lookup sequencer with registered response outputs.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      id_q           <= 1'b0;
      sysmap_rsp_vld <= 1'b0;
      sysmap_rsp_id  <= 1'b0;
      sysmap_rsp_hit <= 1'b0;
      sysmap_rsp_idx <= '0;
      sysmap_rsp_flg <= '0;
    end else begin
      sysmap_rsp_vld <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (gnt_ifu || gnt_lsu) begin
            addr_q  <= gnt_lsu ? lsu_sysmap_req_addr : ifu_sysmap_req_addr;
            id_q    <= gnt_lsu;
            state_q <= ST_LKUP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LKUP: begin
          sysmap_rsp_vld <= 1'b1;
          sysmap_rsp_id  <= id_q;
          sysmap_rsp_hit <= lk_hit;
          sysmap_rsp_idx <= lk_idx;
          sysmap_rsp_flg <= lk_flg;
          state_q        <= ST_RESP;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_mmu_sysmap_ctrl.sv
// Bench for aq_mmu_sysmap_ctrl: register setup, table of lookups, arbitration,
// cp0 write corner cases and reset during a lookup.
module tb_aq_mmu_sysmap_ctrl;
  import aq_mmu_sysmap_pkg::*;

  localparam int EW = 2 + IDX_WIDTH + FLG_WIDTH;

  // ---------------- clock / reset ----------------
  logic                  cpuclk;
  logic                  cpurst_b;
  logic                  ifu_vld, lsu_vld;
  logic [ADDR_WIDTH-1:0] ifu_addr, lsu_addr;
  logic                  ifu_rdy, lsu_rdy;
  logic                  rsp_vld, rsp_id, rsp_hit;
  logic [IDX_WIDTH-1:0]  rsp_idx;
  logic [FLG_WIDTH-1:0]  rsp_flg;
  logic                  wen, sel;
  logic [IDX_WIDTH-1:0]  widx;
  logic [ADDR_WIDTH-1:0] wdata;
  logic                  busy;
  logic [1:0]            dbg_state;

  initial cpuclk = 1'b0;
  always #5 cpuclk = ~cpuclk;

  int cyc = 0;
  always @(posedge cpuclk) cyc++;

  aq_mmu_sysmap_ctrl dut (
    .cpuclk              (cpuclk),
    .cpurst_b            (cpurst_b),
    .ifu_sysmap_req_vld  (ifu_vld),
    .ifu_sysmap_req_addr (ifu_addr),
    .sysmap_ifu_req_rdy  (ifu_rdy),
    .lsu_sysmap_req_vld  (lsu_vld),
    .lsu_sysmap_req_addr (lsu_addr),
    .sysmap_lsu_req_rdy  (lsu_rdy),
    .sysmap_rsp_vld      (rsp_vld),
    .sysmap_rsp_id       (rsp_id),
    .sysmap_rsp_hit      (rsp_hit),
    .sysmap_rsp_idx      (rsp_idx),
    .sysmap_rsp_flg      (rsp_flg),
    .cp0_sysmap_wen      (wen),
    .cp0_sysmap_sel      (sel),
    .cp0_sysmap_idx      (widx),
    .cp0_sysmap_wdata    (wdata),
    .sysmap_cp0_busy     (busy),
    .sysmap_dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [EW-1:0] mk(input logic id, input logic hit,
                                       input logic [IDX_WIDTH-1:0] idx,
                                       input logic [FLG_WIDTH-1:0] flg);
    return {id, hit, idx, flg};
  endfunction

  always @(negedge cpuclk) begin
    if (cpurst_b) begin
      check("cp0_busy_low", busy, 0);
      check("one_rdy_max", ifu_rdy & lsu_rdy, 0);
      check("wen_while_busy", wen & busy, 0);
      if (rsp_vld) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else check("rsp", {rsp_id, rsp_hit, rsp_idx, rsp_flg}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cp0_write(input logic s, input logic [IDX_WIDTH-1:0] i, input logic [ADDR_WIDTH-1:0] d);
    @(posedge cpuclk); #1;
    wen = 1'b1; sel = s; widx = i; wdata = d;
    @(posedge cpuclk); #1;
    wen = 1'b0;
  endtask

  task automatic lookup(input logic id, input logic [ADDR_WIDTH-1:0] a, input logic [EW-1:0] e);
    bit got = 0;
    @(posedge cpuclk); #1;
    if (id) begin lsu_vld = 1'b1; lsu_addr = a; end
    else    begin ifu_vld = 1'b1; ifu_addr = a; end
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge cpuclk);
      if ((id && lsu_rdy) || (!id && ifu_rdy)) begin
        exp_q.push_back(e);
        got = 1;
      end else begin
        @(posedge cpuclk); #1;
      end
    end
    if (!got) check("grant_timeout", 0, 1);
    @(posedge cpuclk); #1;
    if (id) lsu_vld = 1'b0; else ifu_vld = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(negedge cpuclk);
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Both sides held valid; record the first `want` grants.
  task automatic dual_grants(input int want, output int ids[4], output int gcy[4], output int gcnt);
    gcnt = 0;
    for (int n = 0; n < 40 && gcnt < want; n++) begin
      @(negedge cpuclk);
      if (ifu_rdy || lsu_rdy) begin
        ids[gcnt] = int'(lsu_rdy);
        gcy[gcnt] = cyc;
        exp_q.push_back(mk(lsu_rdy, 1'b0, '0, DFLT_FLG));
        gcnt++;
      end
      @(posedge cpuclk); #1;
      if (gcnt == want) begin ifu_vld = 1'b0; lsu_vld = 1'b0; end
    end
    ifu_vld = 1'b0; lsu_vld = 1'b0;
    check("dual_grant_count", gcnt, want);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic                  id;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;
    logic [IDX_WIDTH-1:0]  idx;
    logic [FLG_WIDTH-1:0]  flg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ids[4];
    int gcy[4];
    int gcnt;
    int gc;
    bit got;

    // regions 0/1 only: [0,0x100) dflt, [0x100,0x200) 01110
    vecs[0]  = '{1'b1, 28'h0000150, 1'b1, 3'd1, 5'b01110};
    vecs[1]  = '{1'b1, 28'h0000200, 1'b0, 3'd0, DFLT_FLG};
    vecs[2]  = '{1'b0, 28'h00000FF, 1'b1, 3'd0, DFLT_FLG};
    vecs[3]  = '{1'b0, 28'h0000000, 1'b1, 3'd0, DFLT_FLG};
    vecs[4]  = '{1'b1, 28'h00001FF, 1'b1, 3'd1, 5'b01110};
    vecs[5]  = '{1'b0, 28'h0000100, 1'b1, 3'd1, 5'b01110};
    vecs[6]  = '{1'b1, 28'hFFFFFFF, 1'b0, 3'd0, DFLT_FLG};
    // after top1=0x180, top3=0x400 (region2 empty, region3 from 0), flg3=00101
    vecs[7]  = '{1'b0, 28'h0000150, 1'b1, 3'd1, 5'b01110};
    vecs[8]  = '{1'b1, 28'h0000190, 1'b1, 3'd3, 5'b00101};
    vecs[9]  = '{1'b0, 28'h00003FF, 1'b1, 3'd3, 5'b00101};
    vecs[10] = '{1'b1, 28'h0000400, 1'b0, 3'd0, DFLT_FLG};
    vecs[11] = '{1'b0, 28'h000017F, 1'b1, 3'd1, 5'b01110};

    cpurst_b = 1'b0;
    ifu_vld = 1'b0; lsu_vld = 1'b0; ifu_addr = '0; lsu_addr = '0;
    wen = 1'b0; sel = 1'b0; widx = '0; wdata = '0;

    // ---- reset values ----
    repeat (3) @(negedge cpuclk);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_rsp_id",  rsp_id, 0);
    check("rst_rsp_hit", rsp_hit, 0);
    check("rst_rsp_idx", rsp_idx, 0);
    check("rst_rsp_flg", rsp_flg, 0);
    check("rst_rdy",     {ifu_rdy, lsu_rdy}, 0);
    check("rst_busy",    busy, 0);
    check("rst_state",   dbg_state, 2'b00);

    // ---- arbitration: both valid from reset release ----
    @(posedge cpuclk); #1;
    cpurst_b = 1'b1;
    ifu_vld = 1'b1; ifu_addr = 28'h10;
    lsu_vld = 1'b1; lsu_addr = 28'h20;
    dual_grants(4, ids, gcy, gcnt);
    check("arb_id0", ids[0], 1);
    check("arb_id1", ids[1], 0);
    check("arb_id2", ids[2], 1);
    check("arb_id3", ids[3], 0);
    for (int k = 1; k < 4; k++) check("arb_spacing", gcy[k] - gcy[k-1], 2);
    drain();

    // ---- config and single lookup with latency ----
    cp0_write(1'b0, 3'd0, 28'h100);
    cp0_write(1'b0, 3'd1, 28'h200);
    cp0_write(1'b1, 3'd1, 28'h123450E);   // flags come from the low bits: 01110
    @(posedge cpuclk); #1;
    lsu_vld = 1'b1; lsu_addr = 28'h150;
    got = 0; gc = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge cpuclk);
      if (lsu_rdy) begin got = 1; gc = cyc; exp_q.push_back(mk(1'b1, 1'b1, 3'd1, 5'b01110)); end
      else begin @(posedge cpuclk); #1; end
    end
    check("lat_grant", got, 1);
    @(posedge cpuclk); #1;
    lsu_vld = 1'b0;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge cpuclk);
      if (rsp_vld) got = 1;
    end
    check("lat_rsp_seen", got, 1);
    check("lat_cycles", cyc - gc, 2);
    drain();

    // ---- table part 1 ----
    for (int v = 0; v < 7; v++)
      lookup(vecs[v].id, vecs[v].addr, mk(vecs[v].id, vecs[v].hit, vecs[v].idx, vecs[v].flg));
    drain();

    // ---- cp0 write while the lookup of 0x190 is in LKUP ----
    @(posedge cpuclk); #1;
    ifu_vld = 1'b1; ifu_addr = 28'h190;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge cpuclk);
      if (ifu_rdy) begin got = 1; exp_q.push_back(mk(1'b0, 1'b1, 3'd1, 5'b01110)); end
      else begin @(posedge cpuclk); #1; end
    end
    check("lkw_grant", got, 1);
    @(posedge cpuclk); #1;
    ifu_vld = 1'b0;
    wen = 1'b1; sel = 1'b0; widx = 3'd1; wdata = 28'h180;
    check("lkw_in_lkup", dbg_state, 2'b01);
    @(posedge cpuclk); #1;
    wen = 1'b0;
    drain();
    lookup(1'b0, 28'h190, mk(1'b0, 1'b0, 3'd0, DFLT_FLG));
    drain();

    // ---- cp0 write colliding with an IFU request in IDLE ----
    @(posedge cpuclk); #1;
    check("coll_idle", dbg_state, 2'b00);
    wen = 1'b1; sel = 1'b0; widx = 3'd3; wdata = 28'h400;
    ifu_vld = 1'b1; ifu_addr = 28'h250;
    @(negedge cpuclk);
    check("coll_rdy_blocked", ifu_rdy, 0);
    @(posedge cpuclk); #1;
    wen = 1'b0;
    @(negedge cpuclk);
    check("coll_rdy_next", ifu_rdy, 1);
    if (ifu_rdy) exp_q.push_back(mk(1'b0, 1'b1, 3'd3, DFLT_FLG));
    @(posedge cpuclk); #1;
    ifu_vld = 1'b0;
    drain();

    // ---- table part 2 ----
    cp0_write(1'b1, 3'd3, 28'h5);
    for (int v = 7; v < 12; v++)
      lookup(vecs[v].id, vecs[v].addr, mk(vecs[v].id, vecs[v].hit, vecs[v].idx, vecs[v].flg));
    drain();

    // ---- reset during LKUP ----
    @(posedge cpuclk); #1;
    lsu_vld = 1'b1; lsu_addr = 28'h150;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge cpuclk);
      if (lsu_rdy) got = 1;
      else begin @(posedge cpuclk); #1; end
    end
    check("rst_mid_grant", got, 1);
    @(posedge cpuclk); #1;
    lsu_vld = 1'b0;
    check("rst_mid_lkup", dbg_state, 2'b01);
    #2 cpurst_b = 1'b0;
    #1;
    check("rst_mid_state", dbg_state, 2'b00);
    check("rst_mid_vld",   rsp_vld, 0);
    repeat (2) @(posedge cpuclk);
    #1;
    check("rst_mid_vld_hold", rsp_vld, 0);
    cpurst_b = 1'b1;
    ifu_vld = 1'b1; ifu_addr = 28'h150;
    lsu_vld = 1'b1; lsu_addr = 28'h150;
    dual_grants(2, ids, gcy, gcnt);
    check("rst_first_lsu", ids[0], 1);
    check("rst_second_ifu", ids[1], 0);
    drain();
    repeat (3) @(negedge cpuclk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
